// File: rtl/maj_tt_sweep_ctrl.sv
// Truth-table sweep sequencer: walks every input assignment of an N_IN-input network,
// captures its output into tt and compares the result with a latched expected table.
// Optional MAJ_MISMATCH_CAPTURE_EN adds mis_valid/mis_idx reporting the first differing index.
module maj_tt_sweep_ctrl #(
    parameter int N_IN    = 7,
    parameter int DUT_LAT = 0,
    localparam int TT_W   = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TT_W-1:0] expected_tt,
    output logic [N_IN-1:0] x,
    input  logic            f_in,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt,
    output logic            match
`ifdef MAJ_MISMATCH_CAPTURE_EN
    ,
    output logic            mis_valid,
    output logic [N_IN-1:0] mis_idx
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [N_IN-1:0] IDX_LAST   = '1;
    localparam logic [2:0]      DRAIN_LAST = 3'(DUT_LAT - 1);

    state_t            state_reg, state_next;
    logic [N_IN-1:0]   idx_reg;
    logic [2:0]        drain_reg;
    logic [TT_W-1:0]   exp_reg;
    logic [TT_W-1:0]   tt_reg, tt_next;
    logic              match_reg;
    logic              accept;
    logic              cap_valid;
    logic [N_IN-1:0]   cap_idx;

    assign accept = (state_reg == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_SWEEP;
            end
            S_SWEEP: begin
                busy = 1'b1;
                if (idx_reg == IDX_LAST) state_next = (DUT_LAT == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_reg == DRAIN_LAST) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Index counter saturates at the last assignment; drain counter times the pipeline flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg   <= '0;
            drain_reg <= '0;
            exp_reg   <= '0;
            match_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    idx_reg   <= '0;
                    drain_reg <= '0;
                    if (start) begin
                        exp_reg   <= expected_tt;
                        match_reg <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (idx_reg != IDX_LAST) idx_reg <= idx_reg + 1'b1;
                end
                S_DRAIN: begin
                    drain_reg <= drain_reg + 3'd1;
                end
                default: begin
                    idx_reg   <= '0;
                    drain_reg <= '0;
                end
            endcase
            // The final capture lands on the same edge that enters DONE, so compare the next table.
            if (state_reg != S_DONE && state_next == S_DONE) begin
                match_reg <= (tt_next == exp_reg);
            end
        end
    end

    generate
        if (DUT_LAT == 0) begin : g_lat0
            assign cap_valid = (state_reg == S_SWEEP);
            assign cap_idx   = idx_reg;
        end else begin : g_pipe
            logic [DUT_LAT-1:0] vld_pipe;
            logic [N_IN-1:0]    idx_pipe [DUT_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pipe <= '0;
                    for (int i = 0; i < DUT_LAT; i++) idx_pipe[i] <= '0;
                end else begin
                    vld_pipe[0] <= (state_reg == S_SWEEP);
                    idx_pipe[0] <= idx_reg;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        idx_pipe[i] <= idx_pipe[i-1];
                    end
                end
            end

            assign cap_valid = vld_pipe[DUT_LAT-1];
            assign cap_idx   = idx_pipe[DUT_LAT-1];
        end
    endgenerate

    always_comb begin
        tt_next = tt_reg;
        if (cap_valid) tt_next[cap_idx] = f_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tt_reg <= '0;
        end else if (accept) begin
            tt_reg <= '0;
        end else begin
            tt_reg <= tt_next;
        end
    end

`ifdef MAJ_MISMATCH_CAPTURE_EN
    // Captures arrive in ascending index order, so the first hit is the lowest differing index.
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_valid <= 1'b0;
            mis_idx   <= '0;
        end else if (accept) begin
            mis_valid <= 1'b0;
            mis_idx   <= '0;
        end else if (cap_valid && !mis_valid && (f_in != exp_reg[cap_idx])) begin
            mis_valid <= 1'b1;
            mis_idx   <= cap_idx;
        end
    end
`endif

    assign x     = (state_reg == S_SWEEP || state_reg == S_DRAIN) ? idx_reg : '0;
    assign tt    = tt_reg;
    assign match = match_reg;

endmodule

// File: tb/tb_maj_tt_sweep_ctrl.sv
// Bench for maj_tt_sweep_ctrl: a combinational instance (DUT_LAT=0) and a two-stage pipelined
// instance (DUT_LAT=2) driven by table-lookup networks, checked against expectations from the sweep rules.
module tb_maj_tt_sweep_ctrl;

    localparam int TT_W = 128;
    localparam logic [127:0] MAJ_TT = 128'hfeeaeaaaeee8e880fee8e888aaa8a880;

    logic         clk = 1'b0;
    logic         rst, start, sel;
    logic [127:0] exp_tt, net0, net2;
    logic [6:0]   x0, x2, o_x;
    logic         f0, f2, r1, r2;
    logic         busy0, busy2, done0, done2, match0, match2;
    logic [127:0] tt0, tt2, o_tt;
    logic         o_busy, o_done, o_match;
`ifdef MAJ_MISMATCH_CAPTURE_EN
    logic         mv0, mv2, o_mv;
    logic [6:0]   mi0, mi2, o_mi;
`endif

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    assign f0 = net0[x0];
    always @(posedge clk) begin
        r1 <= net2[x2];
        r2 <= r1;
    end
    assign f2 = r2;

    maj_tt_sweep_ctrl #(.N_IN(7), .DUT_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .expected_tt(exp_tt), .x(x0), .f_in(f0),
        .busy(busy0), .done(done0), .tt(tt0), .match(match0)
`ifdef MAJ_MISMATCH_CAPTURE_EN
        , .mis_valid(mv0), .mis_idx(mi0)
`endif
    );

    maj_tt_sweep_ctrl #(.N_IN(7), .DUT_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .expected_tt(exp_tt), .x(x2), .f_in(f2),
        .busy(busy2), .done(done2), .tt(tt2), .match(match2)
`ifdef MAJ_MISMATCH_CAPTURE_EN
        , .mis_valid(mv2), .mis_idx(mi2)
`endif
    );

    assign o_x     = sel ? x2 : x0;
    assign o_busy  = sel ? busy2 : busy0;
    assign o_done  = sel ? done2 : done0;
    assign o_tt    = sel ? tt2 : tt0;
    assign o_match = sel ? match2 : match0;
`ifdef MAJ_MISMATCH_CAPTURE_EN
    assign o_mv    = sel ? mv2 : mv0;
    assign o_mi    = sel ? mi2 : mi0;
`endif

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
        nvec++;
        assert (obs === req) else begin
            nmis++;
            $error("FAIL %s: observed %h required %h", tag, obs, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int first_diff(input logic [127:0] d);
        for (int i = 0; i < TT_W; i++) if (d[i]) return i;
        return 0;
    endfunction

    task automatic settle;
        int n = 0;
        while ((busy0 || busy2 || done0 || done2) && n < 300) begin
            tick;
            n++;
        end
        chk("settle_timeout", 128'(n < 300), 128'(1));
        tick;
    endtask

    // One full sweep; cycle 1 is the cycle right after the edge that accepts start.
    task automatic sweep(input string tag, input bit s, input logic [127:0] net_v,
                         input logic [127:0] exp_v, input bit hold);
        int cyc, busy_cnt, lat;
        bit xbad;
        settle;
        sel    = s;
        lat    = s ? 2 : 0;
        net0   = net_v;
        net2   = net_v;
        exp_tt = exp_v;
        start  = 1'b1;
        tick;
        start    = 1'b0;
        exp_tt   = ~exp_v;
        cyc      = 1;
        busy_cnt = 0;
        xbad     = 1'b0;
        while (!o_done && cyc < 400) begin
            if (o_busy) busy_cnt++;
            if (cyc <= TT_W) begin
                if (o_x != 7'(cyc - 1)) xbad = 1'b1;
            end else if (cyc <= TT_W + lat) begin
                if (o_x != 7'd127) xbad = 1'b1;
            end
            if (hold && cyc == 10) start = 1'b1;
            tick;
            cyc++;
        end
        chk({tag, "_done_cycle"}, 128'(cyc), 128'(TT_W + lat + 1));
        chk({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(TT_W + lat));
        chk({tag, "_x_sequence"}, 128'(xbad), 128'(0));
        chk({tag, "_tt"}, o_tt, net_v);
        chk({tag, "_match"}, 128'(o_match), 128'(net_v == exp_v));
`ifdef MAJ_MISMATCH_CAPTURE_EN
        chk({tag, "_mis_valid"}, 128'(o_mv), 128'(net_v != exp_v));
        if (net_v != exp_v) chk({tag, "_mis_idx"}, 128'(o_mi), 128'(first_diff(net_v ^ exp_v)));
`endif
        tick;
        chk({tag, "_done_pulse"}, 128'(o_done), 128'(0));
        if (hold) begin
            chk({tag, "_idle_gap"}, 128'(o_busy), 128'(0));
            tick;
            chk({tag, "_restart_busy"}, 128'(o_busy), 128'(1));
            chk({tag, "_restart_x"}, 128'(o_x), 128'(0));
            start = 1'b0;
        end else begin
            chk({tag, "_match_hold"}, 128'(o_match), 128'(net_v == exp_v));
            chk({tag, "_tt_hold"}, o_tt, net_v);
        end
    endtask

    initial begin
        logic [127:0] rnet, rexp;
        int n, seen;
        rst    = 1'b1;
        start  = 1'b0;
        sel    = 1'b0;
        exp_tt = '0;
        net0   = '0;
        net2   = '0;
        repeat (3) tick;
        rst = 1'b0;
        chk("reset_busy", 128'({busy0, busy2}), 128'(0));
        chk("reset_done", 128'({done0, done2}), 128'(0));
        chk("reset_x", 128'({x0, x2}), 128'(0));
        chk("reset_tt0", tt0, 128'(0));
        chk("reset_tt2", tt2, 128'(0));
        chk("reset_match", 128'({match0, match2}), 128'(0));
`ifdef MAJ_MISMATCH_CAPTURE_EN
        chk("reset_mis", 128'({mv0, mv2, mi0, mi2}), 128'(0));
`endif

        sweep("zero_lat0", 1'b0, 128'(0), 128'(0), 1'b0);
        sweep("x0_lat0", 1'b0, {16{8'hAA}}, {16{8'hAA}}, 1'b0);
        sweep("x6_lat2", 1'b1, {{64{1'b1}}, {64{1'b0}}}, {{64{1'b1}}, {64{1'b0}}}, 1'b0);
        sweep("maj_bit5_lat0", 1'b0, MAJ_TT, MAJ_TT ^ (128'(1) << 5), 1'b0);
        sweep("maj_bit5_lat2", 1'b1, MAJ_TT, MAJ_TT ^ (128'(1) << 5), 1'b0);
        sweep("maj_equal_lat2", 1'b1, MAJ_TT, MAJ_TT, 1'b0);

        // Reset in the middle of a sweep discards everything and produces no done.
        settle;
        sel    = 1'b0;
        net0   = MAJ_TT;
        exp_tt = MAJ_TT;
        start  = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (x0 != 7'd40 && n < 200) begin
            tick;
            n++;
        end
        chk("rst_reach_x40", 128'(x0), 128'(40));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_busy", 128'(busy0), 128'(0));
        chk("rst_x", 128'(x0), 128'(0));
        chk("rst_tt", tt0, 128'(0));
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            if (done0 || done2) seen++;
            tick;
        end
        chk("rst_no_done", 128'(seen), 128'(0));
        sweep("after_rst_lat0", 1'b0, MAJ_TT, MAJ_TT, 1'b0);

        sweep("hold_start_lat0", 1'b0, MAJ_TT, MAJ_TT, 1'b1);

        for (int k = 0; k < 6; k++) begin
            rnet = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       rexp = rnet;
                1:       rexp = rnet ^ (128'(1) << $urandom_range(0, 127));
                default: rexp = {$urandom, $urandom, $urandom, $urandom};
            endcase
            sweep($sformatf("rand%0d", k), k[0], rnet, rexp, 1'b0);
        end

        settle;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
